// File: rtl/logic_lab_pkg.sv
// Shared definitions for the logic-lab blocks.
//   NUM_CH           : number of conditioned input channels
//   DEBOUNCE_DEFAULT : default number of stable cycles needed to accept a level
//   ch_vec_t         : one bit per channel
package logic_lab_pkg;

    localparam int NUM_CH           = 3;
    localparam int DEBOUNCE_DEFAULT = 16;

    typedef logic [NUM_CH-1:0] ch_vec_t;

endpackage

// File: rtl/input_conditioner_debounce.sv
// debounce_channel: one conditioned input bit.
// A raw asynchronous input is passed through a 2-flop synchroniser, then
// accepted as the new clean level only after it has differed from the current
// clean level for DEBOUNCE_CYCLES consecutive edges.
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   raw_i    unsynchronised input bit
//   clean_o  debounced level (registered)
//   upd_o    high when clean_o takes a new value on the coming edge
module debounce_channel #(
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic clean_o,
    output logic upd_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             clean_q;
    logic             clean_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any sample equal to the current level restarts qualification, so a
    // bounce back to the old level always costs the full count again.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        upd_o   = 1'b0;
        if (s2_q == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            clean_d = s2_q;
            cnt_d   = '0;
            upd_o   = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= RESET_BIT;
            s2_q    <= RESET_BIT;
            clean_q <= RESET_BIT;
            cnt_q   <= '0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clean_o = clean_q;

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces three raw switch/button
// inputs into clean level signals for the downstream gate blocks, and flags
// every change of the clean levels with a one-cycle strobe.
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   raw[2:0]    unsynchronised external inputs, bit i -> channel i
//   clean[2:0]  debounced levels (clean[0]->in_1/a, [1]->in_2/b, [2]->in_3/c)
//   changed     one-cycle pulse in the cycle clean shows a new value
//   rise[2:0]   per-bit rising-edge pulse   (INPUT_COND_EDGE_EN only)
//   fall[2:0]   per-bit falling-edge pulse  (INPUT_COND_EDGE_EN only)
// Build option: define INPUT_COND_EDGE_EN to add the rise/fall outputs.
// All outputs are taken directly from flops.
module input_conditioner
    import logic_lab_pkg::*;
#(
    parameter int      DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter ch_vec_t RESET_VAL       = '0
) (
    input  logic    clk,
    input  logic    rst_n,
    input  ch_vec_t raw,
    output ch_vec_t clean,
`ifdef INPUT_COND_EDGE_EN
    output ch_vec_t rise,
    output ch_vec_t fall,
`endif
    output logic    changed
);

    ch_vec_t upd;
    logic    changed_q;
    logic    changed_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_BIT      (RESET_VAL[i])
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw_i  (raw[i]),
            .clean_o(clean[i]),
            .upd_o  (upd[i])
        );
    end

    // A set upd bit means that clean bit flips on this edge, so the
    // registered strobe lines up with the cycle the new value is visible.
    assign changed_d = |upd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign changed = changed_q;

`ifdef INPUT_COND_EDGE_EN
    ch_vec_t rise_q;
    ch_vec_t rise_d;
    ch_vec_t fall_q;
    ch_vec_t fall_d;

    // An updating bit always flips, so its old value gives the direction.
    always_comb begin
        rise_d = upd & ~clean;
        fall_d = upd & clean;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

    localparam int D = 4;

    typedef struct packed {
        logic [2:0] clean;
        logic       changed;
        logic [2:0] rise;
        logic [2:0] fall;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] raw = 3'b000;
    logic [2:0] clean;
    logic       changed;
    logic [2:0] rise;
    logic [2:0] fall;

    int vectors = 0;
    int miscompares = 0;

    exp_t       exp_q[$];
    logic [2:0] sync_q[$];
    logic [2:0] win_q[$];
    logic [2:0] m_clean = 3'b000;

    always #5 clk = ~clk;

    input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .RESET_VAL      (3'b000)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (raw),
        .clean  (clean),
`ifdef INPUT_COND_EDGE_EN
        .rise   (rise),
        .fall   (fall),
`endif
        .changed(changed)
    );

`ifndef INPUT_COND_EDGE_EN
    assign rise = 3'b000;
    assign fall = 3'b000;
`endif

    task automatic check_val(input string nm, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference model: a level is accepted once the synchronised input has
    // shown the opposite value on each of the last D active edges.
    always @(posedge clk) begin
        exp_t       e;
        logic [2:0] s2v;
        logic [2:0] nxt;
        bit         all_diff;
        if (!rst_n) begin
            sync_q  = '{3'b000, 3'b000};
            win_q   = {};
            m_clean = 3'b000;
            e       = '0;
        end else begin
            s2v = sync_q.pop_front();
            sync_q.push_back(raw);
            win_q.push_back(s2v);
            if (win_q.size() > D) void'(win_q.pop_front());
            nxt = m_clean;
            if (win_q.size() == D) begin
                for (int c = 0; c < 3; c++) begin
                    all_diff = 1'b1;
                    foreach (win_q[j]) if (win_q[j][c] == m_clean[c]) all_diff = 1'b0;
                    if (all_diff) nxt[c] = ~m_clean[c];
                end
            end
            e.clean   = nxt;
            e.changed = |(nxt ^ m_clean);
            e.rise    = nxt & ~m_clean;
            e.fall    = ~nxt & m_clean;
            m_clean   = nxt;
        end
        exp_q.push_back(e);
    end

    // Monitor: compare every presented output cycle against the scoreboard.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check_val("clean", int'(clean), int'(e.clean));
            check_val("changed", int'(changed), int'(e.changed));
`ifdef INPUT_COND_EDGE_EN
            check_val("rise", int'(rise), int'(e.rise));
            check_val("fall", int'(fall), int'(e.fall));
            check_val("rise_fall_excl", int'(rise & fall), 0);
`endif
        end
    end

    task automatic drive(input logic [2:0] v);
        @(negedge clk);
        raw = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Count changed pulses over n edges, sampled mid-cycle.
    task automatic count_pulses(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(posedge clk);
            #2;
            if (changed) cnt++;
        end
    endtask

    initial begin
        int cnt;
        int hold[3];
        int found;
        logic [2:0] r;

        // 1. Reset behaviour
        idle(3);
        check_val("reset_clean", int'(clean), 0);
        check_val("reset_changed", int'(changed), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b111);
        idle(10);
        check_val("pre_reset_clean", int'(clean), 7);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("async_reset_clean", int'(clean), 0);
        check_val("async_reset_changed", int'(changed), 0);
        idle(3);
        check_val("held_reset_clean", int'(clean), 0);
        rst_n = 1'b1;
        raw = 3'b000;
        idle(8);

        // 2. Clean step: clean[0] rises after edge 5, changed for one cycle
        drive(3'b001);
        for (int k = 0; k <= 6; k++) begin
            @(posedge clk);
            #2;
            check_val("step_clean0", int'(clean[0]), (k >= 5) ? 1 : 0);
            check_val("step_changed", int'(changed), (k == 5) ? 1 : 0);
        end
        drive(3'b000);
        idle(10);

        // 3. Bounce on raw[1]
        drive(3'b010);
        drive(3'b000);
        drive(3'b010);
        drive(3'b000);
        drive(3'b010);
        count_pulses(12, cnt);
        check_val("bounce_pulses", cnt, 1);
        check_val("bounce_clean1", int'(clean[1]), 1);
        drive(3'b000);
        idle(10);

        // 4. Glitch shorter than D on raw[2]
        drive(3'b100);
        idle(2);
        drive(3'b000);
        count_pulses(12, cnt);
        check_val("glitch_pulses", cnt, 0);
        check_val("glitch_clean2", int'(clean[2]), 0);

        // 5. Simultaneous update on two channels
        drive(3'b101);
        count_pulses(10, cnt);
        check_val("simul_pulses", cnt, 1);
        check_val("simul_clean", int'(clean), 5);
        drive(3'b000);
        idle(10);

        // 6. Reset in the middle of a count
        drive(3'b001);
        idle(4);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        found = 0;
        for (int n = 1; n <= 20 && found == 0; n++) begin
            @(posedge clk);
            #2;
            if (clean[0]) found = n;
        end
        check_val("midreset_edge", found, 6);
        drive(3'b000);
        idle(10);

        // Randomised level holds of mixed lengths on all channels
        r = 3'b000;
        foreach (hold[c]) hold[c] = $urandom_range(1, 8);
        repeat (600) begin
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    r[c] = ~r[c];
                    hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 12)
                                                            : $urandom_range(1, 5);
                end
            end
            raw = r;
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        idle(12);
        @(posedge clk);
        #2;
        check_val("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
